// File: rtl/pipe_stall_ctrl.sv
// Pipeline interlock controller for the five-stage CPU.
// Resolves load-use hazards, multiply/divide EX occupancy and memory wait states,
// and drives the per-stage register enables plus the ID/EX bubble control.
// Optional macro STALL_CNT_EN: enables a saturating 32-bit stall-cycle counter;
// when undefined stall_cnt is tied to zero.
module pipe_stall_ctrl #(
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned CW         = 6
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_mdu,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rn,
  input  logic        mem_wait,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        bubble,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_haz;

  // Load in EX whose destination is read by the instruction in ID; r0 never interlocks.
  assign ld_haz = ex_wreg & ex_m2reg & (ex_rn != 5'd0) &
                  ((id_use_rs & (id_rs == ex_rn)) | (id_use_rt & (id_rt == ex_rn)));

  // State and busy-counter registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Prioritised hazard resolution: memory wait, MDU busy, load-use, MDU issue.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    bubble    = 1'b0;
    mdu_start = 1'b0;
    mdu_busy  = (state_q == StBusy);

    if (mem_wait) begin
      // Whole pipe frozen; the MDU count pauses with it.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (state_q == StBusy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      bubble  = 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (ld_haz) begin
      // One bubble suffices: the load reaches MEM next cycle and forwards from there.
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      bubble  = 1'b1;
    end else if (id_mdu) begin
      mdu_start = 1'b1;
      cnt_d     = CW'(MDU_CYCLES - 1);
      state_d   = StBusy;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles in which the front end is held.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt_q <= '0;
    end else if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (default MDU_CYCLES=32).
module tb_pipe_stall_ctrl;

  localparam int unsigned MduCycles = 32;

  // Output vector: {pc,ifid,idex,exmem,memwb,bubble,mdu_start,mdu_busy}
  localparam logic [7:0] VNorm  = 8'b11111_000;
  localparam logic [7:0] VLd    = 8'b00111_100;
  localparam logic [7:0] VIss   = 8'b11111_010;
  localparam logic [7:0] VBusy  = 8'b00111_101;
  localparam logic [7:0] VWaitB = 8'b00000_001;
  localparam logic [7:0] VWaitI = 8'b00000_000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rn = '0;
  logic        id_use_rs = 1'b0, id_use_rt = 1'b0, id_mdu = 1'b0;
  logic        ex_wreg = 1'b0, ex_m2reg = 1'b0, mem_wait = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        bubble, mdu_start, mdu_busy;
  logic [31:0] stall_cnt;

  typedef struct {
    logic [7:0] v;
    string      name;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] sc_model = '0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MDU_CYCLES(MduCycles), .CW(6)) dut (
    .clk       (clk),
    .clr       (clr),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_mdu    (id_mdu),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rn     (ex_rn),
    .mem_wait  (mem_wait),
    .pc_en     (pc_en),
    .ifid_en   (ifid_en),
    .idex_en   (idex_en),
    .exmem_en  (exmem_en),
    .memwb_en  (memwb_en),
    .bubble    (bubble),
    .mdu_start (mdu_start),
    .mdu_busy  (mdu_busy),
    .stall_cnt (stall_cnt)
  );

  function automatic logic [31:0] sc_expect(input logic [31:0] m);
`ifdef STALL_CNT_EN
    return m;
`else
    return 32'h0;
`endif
  endfunction

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rn = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_mdu = 1'b0;
    ex_wreg = 1'b0; ex_m2reg = 1'b0; mem_wait = 1'b0;
  endtask

  // Inputs are already driven (just after a posedge); expectation queued, checked at negedge.
  task automatic cycle(input logic [7:0] v, input string name);
    exp_t e;
    exp_t got;
    logic [7:0] act;
    e.v = v;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, bubble, mdu_start, mdu_busy};
    tests_run++;
    if (act !== got.v) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", got.name, act, got.v, $time);
    end
    if (!got.v[7] && !clr && sc_model != 32'hFFFF_FFFF) sc_model++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_sc(input logic [31:0] req, input string name);
    @(negedge clk);
    tests_run++;
    if (stall_cnt !== req) begin
      tests_failed++;
      $display("FAIL %s: stall_cnt got %0d expected %0d", name, stall_cnt, req);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cycle(VNorm, "clr_held_idle");
    clr = 1'b0;
    sc_model = '0;
  endtask

  task automatic run_busy(input int n, input string name);
    for (int i = 0; i < n; i++) cycle(VBusy, name);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    {id_rs, id_rt, ex_rn} = 15'($urandom);
    {id_use_rs, id_use_rt, id_mdu, ex_wreg, ex_m2reg, mem_wait} = 6'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (mdu_busy !== 1'b0 || stall_cnt !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_held: mdu_busy=%b stall_cnt=%0d expected 0/0", mdu_busy, stall_cnt);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    clr = 1'b0;
    sc_model = '0;
    cycle(VNorm, "reset_release");
    check_sc(32'h0, "reset_stall_cnt");
  endtask

  task automatic test_load_use();
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    cycle(VLd, "ld_rs_stall");
    ex_m2reg = 1'b0;
    cycle(VNorm, "ld_rs_released");
    ex_m2reg = 1'b1; ex_rn = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1; id_use_rs = 1'b0;
    cycle(VLd, "ld_rt_stall");
    clear_inputs();
    cycle(VNorm, "ld_rt_released");
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    cycle(VNorm, "ld_r0_no_stall");
    ex_rn = 5'd7; id_rs = 5'd7; id_use_rs = 1'b0;
    cycle(VNorm, "ld_unused_src");
    ex_wreg = 1'b0; id_use_rs = 1'b1;
    cycle(VNorm, "ld_no_wreg");
    clear_inputs();
  endtask

  task automatic test_mdu();
    id_mdu = 1'b1;
    cycle(VIss, "mdu_issue");
    id_mdu = 1'b0;
    run_busy(5, "mdu_busy_a");
    // ID hazards are ignored while the MDU owns EX.
    id_mdu = 1'b1; ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
    run_busy(4, "mdu_busy_ignore");
    clear_inputs();
    run_busy(MduCycles - 1 - 9, "mdu_busy_b");
    cycle(VNorm, "mdu_done");
    check_sc(sc_expect(sc_model), "mdu_stall_cnt");
  endtask

  task automatic test_mem_wait();
    mem_wait = 1'b1; id_mdu = 1'b1;
    cycle(VWaitI, "wait_idle");
    mem_wait = 1'b0;
    cycle(VIss, "wait_then_issue");
    id_mdu = 1'b0;
    run_busy(10, "wait_busy_pre");
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) cycle(VWaitB, "wait_in_busy");
    mem_wait = 1'b0;
    run_busy(MduCycles - 1 - 10, "wait_busy_post");
    cycle(VNorm, "wait_done");
  endtask

  task automatic test_reset_mid();
    id_mdu = 1'b1;
    cycle(VIss, "mid_issue");
    id_mdu = 1'b0;
    run_busy(9, "mid_busy");
    pulse_clr();
    check_sc(32'h0, "mid_stall_cnt_cleared");
    cycle(VNorm, "mid_idle_after_clr");
    id_mdu = 1'b1;
    cycle(VIss, "mid_fresh_issue");
    id_mdu = 1'b0;
    run_busy(MduCycles - 1, "mid_fresh_busy");
    cycle(VNorm, "mid_fresh_done");
  endtask

  task automatic test_priority();
    id_mdu = 1'b1; ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd12; id_rt = 5'd12; id_use_rt = 1'b1;
    cycle(VLd, "prio_ld_wins");
    ex_m2reg = 1'b0;
    cycle(VIss, "prio_issue_next");
    clear_inputs();
    run_busy(MduCycles - 1, "prio_busy");
    cycle(VNorm, "prio_done");
  endtask

  task automatic test_stall_cnt();
    pulse_clr();
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    cycle(VLd, "sc_ld");
    clear_inputs();
    id_mdu = 1'b1;
    cycle(VIss, "sc_issue");
    id_mdu = 1'b0;
    run_busy(MduCycles - 1, "sc_busy");
    cycle(VNorm, "sc_done");
`ifdef STALL_CNT_EN
    check_sc(32'd32, "sc_total");
`else
    check_sc(32'd0, "sc_total");
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mdu();
    test_mem_wait();
    test_reset_mid();
    test_priority();
    test_stall_cnt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
